mem_read_arbiter: RTL and testbench

Shares one synchronous single-port read memory (1-cycle read latency) between N_REQ independent read requesters, each with its own valid/ready address channel and valid/ready response channel. Sits between address generators and the memory, doing round-robin arbitration, capturing read data into per-requester response registers, and returning data tagged with its address. At most one read per requester is outstanding. With two or more active requesters the memory port sustains one read per cycle.

---
 rtl/mem_read_arbiter_pkg.sv | 14 +
 rtl/mem_read_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mem_read_arbiter.sv | 103 ++++++++++
 tb/tb_mem_read_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared helpers for the memory read arbiter: pointer width calculation.
package mem_read_arbiter_pkg;

    // Bits needed to index n items, never less than one so a 1-entry index still has a wire.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int v = 1; v < n; v = v * 2) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the winning index back.
module rr_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] pick;
    logic [PTR_W:0]   sum;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        rot     = N'({req, req} >> ptr);
        pick    = '0;
        any_gnt = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick    = PTR_W'(k);
                any_gnt = 1'b1;
            end
        end
        sum = {1'b0, pick} + {1'b0, ptr};
        if (sum >= (PTR_W + 1)'(N)) begin
            sum = sum - (PTR_W + 1)'(N);
        end
        gnt_idx = sum[PTR_W-1:0];
        for (int i = 0; i < N; i++) begin
            gnt[i] = any_gnt && (gnt_idx == PTR_W'(i));
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin sharing of a 1-cycle-latency read memory between N_REQ requesters,
// with one outstanding read and one held response register per requester.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    output logic [N_REQ-1:0]        resp_valid_o,
    input  logic [N_REQ-1:0]        resp_ready_i,
    output logic [N_REQ*ADDR_W-1:0] resp_addr_o,
    output logic [N_REQ*DATA_W-1:0] resp_data_o,
    output logic                    mem_enable_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic [DATA_W-1:0]       mem_data_i,
    output logic                    busy_o
);

    localparam int PTR_W = clog2_min1(N_REQ);

    logic [PTR_W-1:0]  ptr;
    logic [N_REQ-1:0]  inflight;
    logic [N_REQ-1:0]  resp_valid;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic [ADDR_W-1:0] addr_q    [N_REQ];
    logic [ADDR_W-1:0] resp_addr [N_REQ];
    logic [DATA_W-1:0] resp_data [N_REQ];

    // Gated by reset so nothing is granted (and no memory read fires) while reset is held.
    assign elig = rst_i ? (req_valid_i & ~inflight & (~resp_valid | resp_ready_i)) : '0;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign req_ready_o  = gnt;
    assign mem_enable_o = any_gnt;
    assign resp_valid_o = resp_valid;
    assign busy_o       = (|inflight) | (|resp_valid);

    always_comb begin
        mem_addr_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr_o = req_addr_i[i*ADDR_W +: ADDR_W];
            end
            resp_addr_o[i*ADDR_W +: ADDR_W] = resp_addr[i];
            resp_data_o[i*DATA_W +: DATA_W] = resp_data[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ptr        <= '0;
            inflight   <= '0;
            resp_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                resp_addr[i] <= '0;
                resp_data[i] <= '0;
            end
        end else begin
            if (any_gnt) begin
                ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            for (int i = 0; i < N_REQ; i++) begin
                // A capture outranks a same-edge consume so the fresh data is never lost.
                if (inflight[i]) begin
                    resp_data[i]  <= mem_data_i;
                    resp_addr[i]  <= addr_q[i];
                    resp_valid[i] <= 1'b1;
                end else if (resp_valid[i] && resp_ready_i[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                // A grant is never given to an in-flight requester, so inflight lasts exactly one cycle.
                inflight[i] <= gnt[i];
            end
        end
    end

    // NOTE: addr_q has no reset; it is only read while inflight is set, which reset clears.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                addr_q[i] <= req_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter (3 requesters) with a per-requester response scoreboard.
module tb_mem_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    resp_valid_o;
    logic [N-1:0]    resp_ready_i;
    logic [N*AW-1:0] resp_addr_o;
    logic [N*DW-1:0] resp_data_o;
    logic            mem_enable_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_i = '0;
    logic            busy_o;

    int total = 0;
    int bad   = 0;
    int accepted [N] = '{0, 0, 0};
    logic [AW+DW-1:0] exp_q [N][$];

    logic [N-1:0]  hold = '0;
    logic [AW-1:0] prev_a [N];
    logic [DW-1:0] prev_d [N];
    logic [AW-1:0] mon_a, mon_na;
    logic [DW-1:0] mon_d;
    logic [AW+DW-1:0] mon_e;

    logic [2:0] seq4 [12] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100,
                              3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
    logic [2:0] seq5 [7]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    logic       rv5  [7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    mem_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_addr_o  (resp_addr_o),
        .resp_data_o  (resp_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .busy_o       (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Requester i issues 0x10 + 0x100*i, stepping by 4 per accepted read.
    function automatic logic [AW-1:0] addr_of(input int i, input int k);
        return AW'(16 + 256 * i + 4 * k);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_grant(input string name, input logic [2:0] gnt, input logic en);
        @(negedge clk_i);
        check({name, "_gnt"}, req_ready_o, gnt);
        check({name, "_en"}, mem_enable_o, en);
    endtask

    // Memory: reads return addr ^ 0x00B5 one cycle after the enable.
    always @(posedge clk_i) begin
        if (mem_enable_o) mem_data_i <= mem_addr_o ^ 16'h00B5;
    end

    always @(posedge clk_i) begin
        #1;
        for (int i = 0; i < N; i++) req_addr_i[i*AW +: AW] = addr_of(i, accepted[i]);
    end

    // Monitor: pushes expectations on acceptance, pops on each consumed response.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            hold = '0;
        end else begin
            check("ready_onehot_valid",
                  ($countones(req_ready_o) <= 1) && ((req_ready_o & ~req_valid_i) == '0), 1);
            for (int i = 0; i < N; i++) begin
                mon_a = resp_addr_o[i*AW +: AW];
                mon_d = resp_data_o[i*DW +: DW];
                if (hold[i]) begin
                    check($sformatf("hold_valid%0d", i), resp_valid_o[i], 1);
                    check($sformatf("hold_addr%0d", i), mon_a, prev_a[i]);
                    check($sformatf("hold_data%0d", i), mon_d, prev_d[i]);
                end
                hold[i]   = resp_valid_o[i] && !resp_ready_i[i];
                prev_a[i] = mon_a;
                prev_d[i] = mon_d;
                if (resp_valid_o[i] && resp_ready_i[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL resp_unexpected req=%0d addr=%0h data=%0h expected none", i, mon_a, mon_d);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check($sformatf("resp_addr%0d", i), mon_a, mon_e[AW+DW-1:DW]);
                        check($sformatf("resp_data%0d", i), mon_d, mon_e[DW-1:0]);
                    end
                end
                if (req_ready_o[i]) begin
                    mon_na = addr_of(i, accepted[i]);
                    exp_q[i].push_back({mon_na, mon_na ^ 16'h00B5});
                    accepted[i]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every requester asking.
        rst_i        = 1'b0;
        req_valid_i  = '1;
        resp_ready_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("rst_ready", req_ready_o, 0);
            check("rst_en", mem_enable_o, 0);
            check("rst_maddr", mem_addr_o, 0);
            check("rst_rvalid", resp_valid_o, 0);
            check("rst_raddr", resp_addr_o, 0);
            check("rst_rdata", resp_data_o, 0);
            check("rst_busy", busy_o, 0);
            step();
        end
        rst_i       = 1'b1;
        req_valid_i = '0;
        step();
        step();

        // Single requester: grants every other cycle, data 0xA5 for address 0x10.
        req_valid_i = 3'b001;
        for (int c = 0; c < 6; c++) begin
            chk_grant("single", (c % 2 == 0) ? 3'b001 : 3'b000, (c % 2 == 0));
            if (c % 2 == 0) check("single_maddr", mem_addr_o, addr_of(0, c / 2));
            if (c == 1) check("single_busy", busy_o, 1);
            if (c == 2) begin
                check("single_rv", resp_valid_o[0], 1);
                check("single_data", resp_data_o[DW-1:0], 16'h00A5);
                check("single_addr", resp_addr_o[AW-1:0], 16'h0010);
            end
            step();
        end
        req_valid_i = '0;
        repeat (3) step();
        check("single_idle_busy", busy_o, 0);

        // Round robin from ptr=1 with all requesters active.
        req_valid_i = '1;
        for (int c = 0; c < 9; c++) begin
            chk_grant("rr", 3'(1 << ((c + 1) % 3)), 1);
            step();
        end
        req_valid_i = '0;
        repeat (3) step();

        // Backpressure on requester 1, released in cycle 11.
        req_valid_i  = '1;
        resp_ready_i = 3'b101;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) resp_ready_i = '1;
            chk_grant("bp", seq4[c], 1);
            if (c == 10) check("bp_held_rv1", resp_valid_o[1], 1);
            step();
        end
        req_valid_i = '0;
        repeat (4) step();

        // Requester 0 holds its response, then consumes and is re-granted in the same cycle.
        req_valid_i  = 3'b001;
        resp_ready_i = 3'b110;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) resp_ready_i = '1;
            if (c == 5) req_valid_i = '0;
            chk_grant("cc", seq5[c], seq5[c] != 3'b000);
            check($sformatf("cc_rv0_c%0d", c), resp_valid_o[0], rv5[c]);
            step();
        end
        repeat (2) step();

        // Reset in the cycle after a grant to requester 0 (ptr moves to 1).
        req_valid_i = 3'b001;
        chk_grant("mr_pre", 3'b001, 1);
        step();
        rst_i       = 1'b0;
        req_valid_i = '0;
        chk_grant("mr_inrst", 3'b000, 0);
        step();
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_grant("mr_post", 3'b000, 0);
            check("mr_post_rv", resp_valid_o, 0);
            check("mr_post_busy", busy_o, 0);
            step();
        end
        req_valid_i = '1;
        chk_grant("mr_first", 3'b001, 1);
        step();
        req_valid_i = '0;
        repeat (4) step();

        for (int i = 0; i < N; i++) check($sformatf("q_empty%0d", i), exp_q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
